// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving the CPU (m0) and the loader/debug port (m1) one-cycle grants on data_memory.
// Define ARB_STATS_EN to add per-requester saturating grant counters with a clear input.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wren,
    output logic                    m0_ack,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    cpu_stall,
    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wren,
    output logic                    m1_ack,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wren,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [CNT_WIDTH-1:0]    m0_count,
    output logic [CNT_WIDTH-1:0]    m1_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   grant0, grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A grant always hands over to the other requester if it is waiting, so
    // a requester holding req high can never be granted twice in a row.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0_req) begin
                    state_d = GNT0;
                end else if (m1_req) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                last_grant_d = 1'b0;
                state_d      = m1_req ? GNT1 : IDLE;
            end
            GNT1: begin
                last_grant_d = 1'b1;
                state_d      = m0_req ? GNT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst keeps a grant cycle that coincides with reset from writing memory.
    assign grant0 = (state_q == GNT0) && !rst;
    assign grant1 = (state_q == GNT1) && !rst;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (grant0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wren  = m0_wren;
            m0_ack    = 1'b1;
            m0_rdata  = mem_rdata;
        end else if (grant1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wren  = m1_wren;
            m1_ack    = 1'b1;
            m1_rdata  = mem_rdata;
        end
    end

    assign cpu_stall = m0_req & ~m0_ack;

`ifdef ARB_STATS_EN
    logic [CNT_WIDTH-1:0] m0_count_q, m0_count_d;
    logic [CNT_WIDTH-1:0] m1_count_q, m1_count_d;

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_comb begin
        m0_count_d = m0_count_q;
        m1_count_d = m1_count_q;
        if (stats_clr) begin
            m0_count_d = '0;
            m1_count_d = '0;
        end else begin
            if (m0_ack && (m0_count_q != {CNT_WIDTH{1'b1}})) begin
                m0_count_d = m0_count_q + CNT_WIDTH'(1);
            end
            if (m1_ack && (m1_count_q != {CNT_WIDTH{1'b1}})) begin
                m1_count_d = m1_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_count_q <= '0;
            m1_count_q <= '0;
        end else begin
            m0_count_q <= m0_count_d;
            m1_count_q <= m1_count_d;
        end
    end

    assign m0_count = m0_count_q;
    assign m1_count = m1_count_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural data memory, per-requester
// scoreboard queues filled when an access is presented and drained on each ack.
module tb_dmem_arbiter;

   typedef struct packed {
      logic        is_read;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

`ifdef ARB_STATS_EN
   localparam int CW = 8;
   logic          stats_clr;
   logic [CW-1:0] m0_count, m1_count;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wren, m1_wren;
   logic        m0_ack, m1_ack, cpu_stall;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wren;

   logic [31:0] mem_array [0:63] = '{default: 32'h0};
   logic [31:0] ref_mem   [0:63] = '{default: 32'h0};

   exp_t exp0_q[$];
   exp_t exp1_q[$];
   exp_t e;

   int compared   = 0;
   int mismatched = 0;

   logic m0_pend = 1'b0;
   logic m1_pend = 1'b0;
   logic req_drop_seen = 1'b0;

   dmem_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
`ifdef ARB_STATS_EN
      ,
      .CNT_WIDTH(CW)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .m0_req(m0_req),
      .m0_addr(m0_addr),
      .m0_wdata(m0_wdata),
      .m0_wren(m0_wren),
      .m0_ack(m0_ack),
      .m0_rdata(m0_rdata),
      .cpu_stall(cpu_stall),
      .m1_req(m1_req),
      .m1_addr(m1_addr),
      .m1_wdata(m1_wdata),
      .m1_wren(m1_wren),
      .m1_ack(m1_ack),
      .m1_rdata(m1_rdata),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_wren(mem_wren),
      .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
      ,
      .stats_clr(stats_clr),
      .m0_count(m0_count),
      .m1_count(m1_count)
`endif
   );

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   // Single-port data memory: combinational read, byte-enabled write on the rising edge
   assign mem_rdata = mem_array[mem_addr[7:2]];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_wren[b]) mem_array[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   // Requester contract watch: a request still waiting at a clock edge must stay high
   always @(posedge clk) begin
      m0_pend <= m0_req & ~m0_ack & ~rst;
      m1_pend <= m1_req & ~m1_ack & ~rst;
   end
   always @(negedge clk) begin
      if ((m0_pend && !m0_req) || (m1_pend && !m1_req)) req_drop_seen <= 1'b1;
   end

   // Present a new m0 access and record what its grant cycle must show
   task automatic drive0(input logic req, input logic [31:0] addr, input logic [3:0] wren, input logic [31:0] wdata);
      exp_t x;
      m0_req = req; m0_addr = addr; m0_wren = wren; m0_wdata = wdata;
      if (req) begin
         x.is_read = (wren == 4'h0);
         x.addr    = addr;
         if (wren == 4'h0) begin
            x.data = ref_mem[addr[7:2]];
         end else begin
            for (int b = 0; b < 4; b++) if (wren[b]) ref_mem[addr[7:2]][b*8 +: 8] = wdata[b*8 +: 8];
            x.data = wdata;
         end
         exp0_q.push_back(x);
      end
   endtask

   // Present a new m1 access and record what its grant cycle must show
   task automatic drive1(input logic req, input logic [31:0] addr, input logic [3:0] wren, input logic [31:0] wdata);
      exp_t x;
      m1_req = req; m1_addr = addr; m1_wren = wren; m1_wdata = wdata;
      if (req) begin
         x.is_read = (wren == 4'h0);
         x.addr    = addr;
         if (wren == 4'h0) begin
            x.data = ref_mem[addr[7:2]];
         end else begin
            for (int b = 0; b < 4; b++) if (wren[b]) ref_mem[addr[7:2]][b*8 +: 8] = wdata[b*8 +: 8];
            x.data = wdata;
         end
         exp1_q.push_back(x);
      end
   endtask

   // Outputs must be quiet in reset while cpu_stall follows m0_req
   task automatic test_reset();
      rst = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h44; m0_wdata = 32'hFFFF_FFFF; m0_wren = 4'hF;
      m1_req = 1'b1; m1_addr = 32'h48; m1_wdata = 32'h1111_1111; m1_wren = 4'hF;
`ifdef ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++; if (m0_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m0_ack got=%b want=0", m0_ack); end
      compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m1_ack got=%b want=0", m1_ack); end
      compared++; if (mem_wren !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_mem_wren got=%h want=0", mem_wren); end
      compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr got=%h want=0", mem_addr); end
      compared++; if (mem_wdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
      compared++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata got=%h/%h want=0/0", m0_rdata, m1_rdata); end
      compared++; if (cpu_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cpu_stall got=%b want=1", cpu_stall); end
`ifdef ARB_STATS_EN
      compared++; if (m0_count !== '0 || m1_count !== '0) begin mismatched++; $display("[TB] FAIL reset_counts got=%0d/%0d want=0/0", m0_count, m1_count); end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      drive0(1'b0, 32'h0, 4'h0, 32'h0);
      drive1(1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // m0 writes 0xDEADBEEF to 0x10 then reads it back, holding req across both
   task automatic test_write_read();
      drive0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
      @(negedge clk);
      compared++; if (m0_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_c0_ack got=%b want=0", m0_ack); end
      compared++; if (cpu_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_c0_stall got=%b want=1", cpu_stall); end
      @(posedge clk); #1;
      @(negedge clk);
      compared++; if (m0_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_c1_ack got=%b want=1", m0_ack); end
      compared++; if (cpu_stall !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_c1_stall got=%b want=0", cpu_stall); end
      compared++; if (mem_wren !== 4'hF) begin mismatched++; $display("[TB] FAIL wr_c1_wren got=%h want=f", mem_wren); end
      if (m0_ack) begin
         compared++;
         if (exp0_q.size() == 0) begin mismatched++; $display("[TB] FAIL wr_sb0 got=ack want=no_ack"); end
         else begin
            e = exp0_q.pop_front();
            if ((mem_addr !== e.addr) || (e.is_read ? (m0_rdata !== e.data) : (mem_wdata !== e.data))) begin
               mismatched++; $display("[TB] FAIL wr_sb0 addr=%h rdata=%h wdata=%h want addr=%h data=%h", mem_addr, m0_rdata, mem_wdata, e.addr, e.data);
            end
         end
      end
      @(posedge clk); #1;
      drive0(1'b1, 32'h10, 4'h0, 32'h0);
      @(negedge clk);
      compared++; if (m0_ack !== 1'b0 || mem_wren !== 4'h0) begin mismatched++; $display("[TB] FAIL rd_c0 ack=%b wren=%h want 0/0", m0_ack, mem_wren); end
      compared++; if (cpu_stall !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_c0_stall got=%b want=1", cpu_stall); end
      @(posedge clk); #1;
      @(negedge clk);
      compared++; if (m0_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL rd_c1_ack got=%b want=1", m0_ack); end
      if (m0_ack) begin
         compared++;
         if (exp0_q.size() == 0) begin mismatched++; $display("[TB] FAIL rd_sb0 got=ack want=no_ack"); end
         else begin
            e = exp0_q.pop_front();
            if ((mem_addr !== e.addr) || (e.is_read ? (m0_rdata !== e.data) : (mem_wdata !== e.data))) begin
               mismatched++; $display("[TB] FAIL rd_sb0 addr=%h rdata=%h wdata=%h want addr=%h data=%h", mem_addr, m0_rdata, mem_wdata, e.addr, e.data);
            end
         end
      end
      @(posedge clk); #1;
      drive0(1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // Both requests rise together straight out of reset: m0 first, m1 right after
   task automatic test_both_rise();
      logic [1:0] want [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive0(1'b1, 32'h10, 4'h0, 32'h0);
      drive1(1'b1, 32'h10, 4'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         compared++;
         if ({m0_ack, m1_ack} !== want[c]) begin mismatched++; $display("[TB] FAIL both_c%0d_acks got=%b want=%b", c, {m0_ack, m1_ack}, want[c]); end
         if (m0_ack) begin
            compared++;
            if (exp0_q.size() == 0 || m1_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL both_sb0 qsize=%0d m1_rdata=%h want nonempty/0", exp0_q.size(), m1_rdata); end
            else begin
               e = exp0_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m0_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL both_sb0 addr=%h rdata=%h want addr=%h data=%h", mem_addr, m0_rdata, e.addr, e.data);
               end
            end
         end
         if (m1_ack) begin
            compared++;
            if (exp1_q.size() == 0 || m0_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL both_sb1 qsize=%0d m0_rdata=%h want nonempty/0", exp1_q.size(), m0_rdata); end
            else begin
               e = exp1_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m1_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL both_sb1 addr=%h rdata=%h want addr=%h data=%h", mem_addr, m1_rdata, e.addr, e.data);
               end
            end
         end
         @(posedge clk); #1;
         if (c == 1) drive0(1'b0, 32'h0, 4'h0, 32'h0);
         if (c == 2) drive1(1'b0, 32'h0, 4'h0, 32'h0);
      end
   endtask

   // Both held high for eight grant cycles: strict alternation, four acks each
   task automatic test_alternate();
      int   cnt0 = 0;
      int   cnt1 = 0;
      logic a0, a1, w0, w1;
      drive0(1'b1, 32'h40, 4'hF, 32'hC0DE_0000);
      drive1(1'b1, 32'h10, 4'h0, 32'h0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         a0 = m0_ack; a1 = m1_ack;
         w0 = (c % 2 == 1) && (c <= 7);
         w1 = (c % 2 == 0) && (c >= 2) && (c <= 8);
         compared++;
         if (a0 !== w0 || a1 !== w1) begin mismatched++; $display("[TB] FAIL alt_c%0d_acks got=%b%b want=%b%b", c, a0, a1, w0, w1); end
         compared++;
         if (mem_wren !== (a0 ? 4'hF : 4'h0)) begin mismatched++; $display("[TB] FAIL alt_c%0d_wren got=%h want=%h", c, mem_wren, (a0 ? 4'hF : 4'h0)); end
         if (a0) begin
            cnt0++;
            compared++;
            if (exp0_q.size() == 0) begin mismatched++; $display("[TB] FAIL alt_sb0 got=ack want=no_ack"); end
            else begin
               e = exp0_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m0_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL alt_sb0 addr=%h wdata=%h want addr=%h data=%h", mem_addr, mem_wdata, e.addr, e.data);
               end
            end
         end
         if (a1) begin
            cnt1++;
            compared++;
            if (exp1_q.size() == 0) begin mismatched++; $display("[TB] FAIL alt_sb1 got=ack want=no_ack"); end
            else begin
               e = exp1_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m1_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL alt_sb1 addr=%h rdata=%h want addr=%h data=%h", mem_addr, m1_rdata, e.addr, e.data);
               end
            end
         end
         @(posedge clk); #1;
         if (a0) begin
            if (cnt0 < 4) drive0(1'b1, 32'h40 + 32'(4 * cnt0), 4'hF, 32'hC0DE_0000 + 32'(cnt0));
            else          drive0(1'b0, 32'h0, 4'h0, 32'h0);
         end
         if (a1) begin
            if (cnt1 < 4) drive1(1'b1, 32'h10, 4'h0, 32'h0);
            else          drive1(1'b0, 32'h0, 4'h0, 32'h0);
         end
      end
      compared++;
      if (cnt0 != 4 || cnt1 != 4) begin mismatched++; $display("[TB] FAIL alt_counts got=%0d/%0d want=4/4", cnt0, cnt1); end
   endtask

   // m1 alone with req held: an ack every other cycle, idle cycles never write
   task automatic test_m1_only();
      int   cnt1 = 0;
      logic a1;
      drive1(1'b1, 32'h24, 4'hF, 32'h5A5A_0000);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         a1 = m1_ack;
         compared++;
         if (a1 !== ((c % 2 == 1) && (c <= 5)) || m0_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL m1only_c%0d_acks got=%b%b want=0%b", c, m0_ack, a1, ((c % 2 == 1) && (c <= 5))); end
         compared++;
         if (mem_wren !== (a1 ? 4'hF : 4'h0)) begin mismatched++; $display("[TB] FAIL m1only_c%0d_wren got=%h want=%h", c, mem_wren, (a1 ? 4'hF : 4'h0)); end
         if (a1) begin
            cnt1++;
            compared++;
            if (exp1_q.size() == 0) begin mismatched++; $display("[TB] FAIL m1only_sb1 got=ack want=no_ack"); end
            else begin
               e = exp1_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m1_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL m1only_sb1 addr=%h wdata=%h want addr=%h data=%h", mem_addr, mem_wdata, e.addr, e.data);
               end
            end
         end
         @(posedge clk); #1;
         if (a1) begin
            if (cnt1 < 3) drive1(1'b1, 32'h24 + 32'(4 * cnt1), 4'hF, 32'h5A5A_0000 + 32'(cnt1));
            else          drive1(1'b0, 32'h0, 4'h0, 32'h0);
         end
      end
   endtask

   // Reset lands on a GNT1 write to 0x20: no write happens, the request is served after reset
   task automatic test_reset_mid_grant();
      drive1(1'b1, 32'h20, 4'hF, 32'h1234_5678);
      @(negedge clk);
      compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rmg_c0_ack got=%b want=0", m1_ack); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      compared++; if (m1_ack !== 1'b0 || mem_wren !== 4'h0) begin mismatched++; $display("[TB] FAIL rmg_rst_cycle ack=%b wren=%h want 0/0", m1_ack, mem_wren); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      compared++; if (mem_array[8] !== 32'h0) begin mismatched++; $display("[TB] FAIL rmg_mem20 got=%h want=00000000", mem_array[8]); end
      compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rmg_after0_ack got=%b want=0", m1_ack); end
      @(posedge clk); #1;
      @(negedge clk);
      compared++; if (m1_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL rmg_after1_ack got=%b want=1", m1_ack); end
      for (int k = 0; k < 2; k++) begin
         if (m1_ack) begin
            compared++;
            if (exp1_q.size() == 0) begin mismatched++; $display("[TB] FAIL rmg_sb1 got=ack want=no_ack"); end
            else begin
               e = exp1_q.pop_front();
               if ((mem_addr !== e.addr) || (e.is_read ? (m1_rdata !== e.data) : (mem_wdata !== e.data))) begin
                  mismatched++; $display("[TB] FAIL rmg_sb1 addr=%h rdata=%h wdata=%h want addr=%h data=%h", mem_addr, m1_rdata, mem_wdata, e.addr, e.data);
               end
            end
         end
         @(posedge clk); #1;
         if (k == 0) begin
            drive1(1'b1, 32'h20, 4'h0, 32'h0);
            @(negedge clk);
            compared++; if (m1_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rmg_rd_idle_ack got=%b want=0", m1_ack); end
            @(posedge clk); #1;
            @(negedge clk);
            compared++; if (m1_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL rmg_rd_ack got=%b want=1", m1_ack); end
         end else begin
            drive1(1'b0, 32'h0, 4'h0, 32'h0);
         end
      end
   endtask

`ifdef ARB_STATS_EN
   // Counters saturate at all-ones and clear wins over a same-cycle ack
   task automatic test_stats();
      int acks = 0;
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      @(negedge clk);
      compared++; if (m0_count !== '0 || m1_count !== '0) begin mismatched++; $display("[TB] FAIL stats_clr got=%0d/%0d want=0/0", m0_count, m1_count); end
      m0_req = 1'b1; m0_addr = 32'h10; m0_wren = 4'h0; m0_wdata = 32'h0;
      for (int c = 0; c < 700 && acks < 300; c++) begin
         @(negedge clk);
         if (m0_ack) acks++;
         @(posedge clk); #1;
         if (acks >= 300) m0_req = 1'b0;
      end
      m0_req = 1'b0;
      @(negedge clk);
      compared++; if (acks != 300) begin mismatched++; $display("[TB] FAIL stats_ack_budget got=%0d want=300", acks); end
      compared++; if (m0_count !== {CW{1'b1}}) begin mismatched++; $display("[TB] FAIL stats_sat got=%h want=%h", m0_count, {CW{1'b1}}); end
      compared++; if (m1_count !== '0) begin mismatched++; $display("[TB] FAIL stats_m1 got=%0d want=0", m1_count); end
      @(posedge clk); #1;
      m0_req = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b1;
      @(negedge clk);
      compared++; if (m0_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL stats_clr_ack got=%b want=1", m0_ack); end
      @(posedge clk); #1;
      stats_clr = 1'b0;
      m0_req = 1'b0;
      @(negedge clk);
      compared++; if (m0_count !== '0) begin mismatched++; $display("[TB] FAIL stats_clr_vs_ack got=%0d want=0", m0_count); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wren = '0;
      m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wren = '0;
`ifdef ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      test_reset();
      test_write_read();
      test_both_rise();
      test_alternate();
      test_m1_only();
      test_reset_mid_grant();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      compared++;
      if (exp0_q.size() != 0 || exp1_q.size() != 0) begin mismatched++; $display("[TB] FAIL sb_leftover got=%0d/%0d want=0/0", exp0_q.size(), exp1_q.size()); end
      compared++;
      if (req_drop_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL req_dropped_before_ack got=%b want=0", req_drop_seen); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
